// File: rtl/video_timing_pkg.sv
// video_timing_pkg: default 640x480 timing constants and raster decode helpers.
// Shared by video_timing_gen and pixel_prescaler.
package video_timing_pkg;

   localparam int DEF_DIV      = 10;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;
   localparam int DEF_ADDR_W   = 20;

   typedef enum logic [1:0] {
      ACTIVE,
      FRONT,
      SYNC,
      BACK
   } sync_region_t;

   function automatic int h_total(input int act, input int fp,
                                  input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic int v_total(input int act, input int fp,
                                  input int sync, input int bp);
      return act + fp + sync + bp;
   endfunction

   function automatic sync_region_t region(input int pos, input int act,
                                           input int fp, input int sync);
      sync_region_t r;
      if (pos < act)
         r = ACTIVE;
      else if (pos < act + fp)
         r = FRONT;
      else if (pos < act + fp + sync)
         r = SYNC;
      else
         r = BACK;
      return r;
   endfunction

endpackage

// File: rtl/video_timing_gen_prescaler.sv
// pixel_prescaler: divides clk by DIV into a registered pixel enable.
// tick is only updated while enabled, so a pending tick survives a hold.
module pixel_prescaler
   import video_timing_pkg::*;
#(
   parameter int DIV = DEF_DIV
) (
   input  logic clk,
   input  logic n_rst,
   input  logic enable,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (enable) begin
         tick <= (cnt == LAST);
         cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing generator (col/row, syncs, active, address).
// Optional per-line interrupt is built when VIDEO_TIMING_LINE_IRQ_EN is defined.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int DIV      = DEF_DIV,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit SYNC_POL = 1'b0,
   parameter int ADDR_W   = DEF_ADDR_W,
   localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
   localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
   localparam int COL_W   = $clog2(H_TOTAL),
   localparam int ROW_W   = $clog2(V_TOTAL)
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              enable,
`ifdef VIDEO_TIMING_LINE_IRQ_EN
   input  logic [ROW_W-1:0]  irq_line,
   output logic              line_irq,
`endif
   output logic              pixel_tick,
   output logic [COL_W-1:0]  col,
   output logic [ROW_W-1:0]  row,
   output logic [ADDR_W-1:0] addr,
   output logic              active,
   output logic              hsync,
   output logic              vsync,
   output logic              line_start,
   output logic              frame_start
);

   logic         tick_q;
   logic         adv;
   logic         col_wrap;
   logic         row_wrap;
   logic         ls_q;
   logic         fs_q;
   sync_region_t h_reg;
   sync_region_t v_reg;

   pixel_prescaler #(.DIV(DIV)) u_prescaler (
      .clk   (clk),
      .n_rst (n_rst),
      .enable(enable),
      .tick  (tick_q)
   );

   // Counters step on the edge that closes a tick cycle.
   assign adv      = tick_q & enable;
   assign col_wrap = (col == COL_W'(H_TOTAL - 1));
   assign row_wrap = (row == ROW_W'(V_TOTAL - 1));

   assign h_reg  = region(int'(col), H_ACTIVE, H_FP, H_SYNC);
   assign v_reg  = region(int'(row), V_ACTIVE, V_FP, V_SYNC);
   assign active = (h_reg == ACTIVE) && (v_reg == ACTIVE);
   assign hsync  = (h_reg == SYNC) ? SYNC_POL : ~SYNC_POL;
   assign vsync  = (v_reg == SYNC) ? SYNC_POL : ~SYNC_POL;

   assign pixel_tick  = adv;
   assign line_start  = ls_q & enable;
   assign frame_start = fs_q & enable;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         col  <= '0;
         row  <= '0;
         addr <= '0;
         ls_q <= 1'b0;
         fs_q <= 1'b0;
      end else begin
         ls_q <= adv & col_wrap;
         fs_q <= adv & col_wrap & row_wrap;
         if (adv) begin
            col <= col_wrap ? '0 : col + 1'b1;
            if (col_wrap)
               row <= row_wrap ? '0 : row + 1'b1;
            if (col_wrap && row_wrap)
               addr <= '0;
            else if (active)
               addr <= addr + 1'b1;
         end
      end
   end

`ifdef VIDEO_TIMING_LINE_IRQ_EN
   logic [ROW_W-1:0] next_row;
   logic             irq_q;

   assign next_row = row_wrap ? '0 : row + 1'b1;
   assign line_irq = irq_q & enable;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         irq_q <= 1'b0;
      else
         irq_q <= adv & col_wrap & (next_row == irq_line);
   end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for a default and a tiny raster.
// Build with VIDEO_TIMING_LINE_IRQ_EN defined to also cover line_irq.
module tb_video_timing_gen;

   localparam int SH_ACT = 4, SH_FP = 1, SH_SYNC = 2, SH_BP = 1;
   localparam int SV_ACT = 3, SV_FP = 1, SV_SYNC = 1, SV_BP = 1;
   localparam int SH_TOT = 8;
   localparam int SV_TOT = 6;
   localparam int FRAME  = SH_TOT * SV_TOT;

   localparam int S_TICK = 0, S_COL = 1, S_ROW = 2, S_ADDR = 3;
   localparam int S_ACT = 4, S_HS = 5, S_VS = 6, S_LS = 7;
   localparam int S_FS = 8, S_IRQ = 9;

   typedef struct {
      int cyc;
      int dut;
      int sig;
      int val;
   } exp_t;

   exp_t  exp_q[$];
   int    tests = 0;
   int    fails = 0;
   int    cyc = 0;
   bit    done = 1'b0;
   string sig_name [10] = '{"pixel_tick", "col", "row", "addr", "active",
                            "hsync", "vsync", "line_start", "frame_start",
                            "line_irq"};

   logic clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic        b_n_rst, b_en, b_tick, b_active, b_hs, b_vs, b_ls, b_fs;
   logic [9:0]  b_col, b_row;
   logic [19:0] b_addr;
   logic        s_n_rst, s_en, s_tick, s_active, s_hs, s_vs, s_ls, s_fs;
   logic [2:0]  s_col, s_row;
   logic [19:0] s_addr;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
   logic [9:0]  b_irq_line;
   logic        b_irq;
   logic [2:0]  s_irq_line;
   logic        s_irq;
`endif

   video_timing_gen u_big (
      .clk        (clk),
      .n_rst      (b_n_rst),
      .enable     (b_en),
`ifdef VIDEO_TIMING_LINE_IRQ_EN
      .irq_line   (b_irq_line),
      .line_irq   (b_irq),
`endif
      .pixel_tick (b_tick),
      .col        (b_col),
      .row        (b_row),
      .addr       (b_addr),
      .active     (b_active),
      .hsync      (b_hs),
      .vsync      (b_vs),
      .line_start (b_ls),
      .frame_start(b_fs)
   );

   video_timing_gen #(
      .DIV(1),
      .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
      .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
   ) u_small (
      .clk        (clk),
      .n_rst      (s_n_rst),
      .enable     (s_en),
`ifdef VIDEO_TIMING_LINE_IRQ_EN
      .irq_line   (s_irq_line),
      .line_irq   (s_irq),
`endif
      .pixel_tick (s_tick),
      .col        (s_col),
      .row        (s_row),
      .addr       (s_addr),
      .active     (s_active),
      .hsync      (s_hs),
      .vsync      (s_vs),
      .line_start (s_ls),
      .frame_start(s_fs)
   );

   function automatic int actual(input int d, input int s);
      int v;
      v = -1;
      if (d == 0) begin
         case (s)
            S_TICK: v = int'(b_tick);
            S_COL:  v = int'(b_col);
            S_ROW:  v = int'(b_row);
            S_ADDR: v = int'(b_addr);
            S_ACT:  v = int'(b_active);
            S_HS:   v = int'(b_hs);
            S_VS:   v = int'(b_vs);
            S_LS:   v = int'(b_ls);
            S_FS:   v = int'(b_fs);
`ifdef VIDEO_TIMING_LINE_IRQ_EN
            S_IRQ:  v = int'(b_irq);
`endif
            default: v = -1;
         endcase
      end else begin
         case (s)
            S_TICK: v = int'(s_tick);
            S_COL:  v = int'(s_col);
            S_ROW:  v = int'(s_row);
            S_ADDR: v = int'(s_addr);
            S_ACT:  v = int'(s_active);
            S_HS:   v = int'(s_hs);
            S_VS:   v = int'(s_vs);
            S_LS:   v = int'(s_ls);
            S_FS:   v = int'(s_fs);
`ifdef VIDEO_TIMING_LINE_IRQ_EN
            S_IRQ:  v = int'(s_irq);
`endif
            default: v = -1;
         endcase
      end
      return v;
   endfunction

   task automatic expect_at(input int c, input int d, input int s,
                            input int v);
      exp_t e;
      e.cyc = c;
      e.dut = d;
      e.sig = s;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic expect_reset(input int c, input int d);
      expect_at(c, d, S_TICK, 0);
      expect_at(c, d, S_COL, 0);
      expect_at(c, d, S_ROW, 0);
      expect_at(c, d, S_ADDR, 0);
      expect_at(c, d, S_ACT, 1);
      expect_at(c, d, S_HS, 1);
      expect_at(c, d, S_VS, 1);
      expect_at(c, d, S_LS, 0);
      expect_at(c, d, S_FS, 0);
`ifdef VIDEO_TIMING_LINE_IRQ_EN
      expect_at(c, d, S_IRQ, 0);
`endif
   endtask

   // Hand-derived picture of the tiny raster at pixel position p.
   task automatic expect_small(input int c, input int p, input int irq_row);
      int  x, y, a;
      bit  vis;
      x   = p % SH_TOT;
      y   = (p / SH_TOT) % SV_TOT;
      vis = (x < 4) && (y < 3);
      if (y >= 3)
         a = 12;
      else if (x < 4)
         a = y * 4 + x;
      else
         a = y * 4 + 4;
      expect_at(c, 1, S_TICK, 1);
      expect_at(c, 1, S_COL, x);
      expect_at(c, 1, S_ROW, y);
      expect_at(c, 1, S_ADDR, a);
      expect_at(c, 1, S_ACT, int'(vis));
      expect_at(c, 1, S_HS, (x == 5 || x == 6) ? 0 : 1);
      expect_at(c, 1, S_VS, (y == 4) ? 0 : 1);
      expect_at(c, 1, S_LS, (x == 0 && p > 0) ? 1 : 0);
      expect_at(c, 1, S_FS, (p % FRAME == 0 && p > 0) ? 1 : 0);
`ifdef VIDEO_TIMING_LINE_IRQ_EN
      expect_at(c, 1, S_IRQ,
                (x == 0 && y == irq_row && p > 0) ? 1 : 0);
`else
      if (irq_row > SV_TOT) expect_at(c, 1, S_IRQ, 0);
`endif
   endtask

   task automatic to_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int act;
      forever begin
         @(negedge clk);
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc == cyc) begin
               act = actual(exp_q[i].dut, exp_q[i].sig);
               tests++;
               if (act != exp_q[i].val) begin
                  fails++;
                  $display("FAIL %s dut%0d cyc %0d: got %0d, want %0d",
                           sig_name[exp_q[i].sig], exp_q[i].dut, cyc,
                           act, exp_q[i].val);
               end
               exp_q.delete(i);
            end
         end
         if (done) begin
            foreach (exp_q[i]) begin
               tests++;
               fails++;
               $display("FAIL %s dut%0d cyc %0d: never sampled, want %0d",
                        sig_name[exp_q[i].sig], exp_q[i].dut,
                        exp_q[i].cyc, exp_q[i].val);
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, s0, r0;
      b_n_rst = 1'b0;
      b_en    = 1'b0;
      s_n_rst = 1'b0;
      s_en    = 1'b0;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
      b_irq_line = 10'd0;
      s_irq_line = 3'd2;
`endif
      #1;
      expect_reset(1, 0);
      expect_reset(1, 1);
      to_cyc(2);
      b_n_rst = 1'b1;
      s_n_rst = 1'b1;
      expect_reset(3, 0);
      expect_reset(3, 1);

      // Default raster, DIV=10: tick cadence and a 25-clk hold at col 3.
      to_cyc(4);
      p0 = cyc;
      b_en = 1'b1;
      expect_at(p0,      0, S_TICK, 0);
      expect_at(p0 + 9,  0, S_TICK, 0);
      expect_at(p0 + 10, 0, S_TICK, 1);
      expect_at(p0 + 10, 0, S_COL, 0);
      expect_at(p0 + 11, 0, S_TICK, 0);
      expect_at(p0 + 11, 0, S_COL, 1);
      expect_at(p0 + 20, 0, S_TICK, 1);
      expect_at(p0 + 21, 0, S_COL, 2);
      expect_at(p0 + 31, 0, S_COL, 3);
      expect_at(p0 + 31, 0, S_ADDR, 3);
      expect_at(p0 + 40, 0, S_TICK, 0);
      expect_at(p0 + 45, 0, S_COL, 3);
      expect_at(p0 + 45, 0, S_ADDR, 3);
      expect_at(p0 + 50, 0, S_TICK, 0);
      expect_at(p0 + 50, 0, S_LS, 0);
      expect_at(p0 + 50, 0, S_ACT, 1);
      expect_at(p0 + 50, 0, S_HS, 1);
      expect_at(p0 + 57, 0, S_COL, 3);
      expect_at(p0 + 64, 0, S_TICK, 0);
      expect_at(p0 + 64, 0, S_COL, 3);
      expect_at(p0 + 65, 0, S_TICK, 1);
      expect_at(p0 + 66, 0, S_TICK, 0);
      expect_at(p0 + 66, 0, S_COL, 4);
      expect_at(p0 + 66, 0, S_ROW, 0);
      expect_at(p0 + 66, 0, S_ADDR, 4);
      to_cyc(p0 + 33);
      b_en = 1'b0;
      to_cyc(p0 + 58);
      b_en = 1'b1;
      to_cyc(p0 + 70);
      b_en = 1'b0;

      // Tiny raster, DIV=1: two full frames then reset at row 2, col 5.
      to_cyc(80);
      s0 = cyc;
      s_en = 1'b1;
      for (int p = 0; p <= 2 * FRAME + 21; p++)
         expect_small(s0 + 1 + p, p, 2);
      to_cyc(s0 + 2 * FRAME + 23);
      s_n_rst = 1'b0;
`ifdef VIDEO_TIMING_LINE_IRQ_EN
      s_irq_line = 3'd7;
`endif
      expect_reset(cyc, 1);
      to_cyc(cyc + 1);
      r0 = cyc;
      expect_reset(r0, 1);
      s_n_rst = 1'b1;
      for (int p = 0; p <= FRAME + 2; p++)
         expect_small(r0 + 1 + p, p, -1);
      to_cyc(r0 + FRAME + 8);
      done = 1'b1;
   end

endmodule
